// File: rtl/edge_event_arbiter.sv
// Edge detector with per-channel pending/overflow flags and a one-entry
// round-robin event register that drains pending channels back-to-back.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [1:0]        cfg_edge_type_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic              evt_rise_o,
  output logic              evt_fall_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] ovf_o
);

  localparam logic [0:0]      ST_EMPTY = 1'b0;
  localparam logic [0:0]      ST_FULL  = 1'b1;
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]      r_a_prev;
  logic [NUM_CH-1:0]      r_rise_pend;
  logic [NUM_CH-1:0]      r_fall_pend;
  logic [NUM_CH-1:0]      r_ovf;
  logic [NUM_CH-1:0]      r_pend;
  logic [NUM_CH-1:0][1:0] r_edge_type;
  logic [0:0]             r_state;
  logic [CH_W-1:0]        r_rr_ptr;
  logic [CH_W-1:0]        r_evt_ch;
  logic                   r_evt_rise;
  logic                   r_evt_fall;

  logic [NUM_CH-1:0] w_rise_det;
  logic [NUM_CH-1:0] w_fall_det;
  logic [NUM_CH-1:0] w_rise_en;
  logic [NUM_CH-1:0] w_fall_en;
  logic [NUM_CH-1:0] w_cfg_hit;
  logic [NUM_CH-1:0] w_cand;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_rise_nxt;
  logic [NUM_CH-1:0] w_fall_nxt;
  logic [NUM_CH-1:0] w_ovf_nxt;
  logic [CH_W-1:0]   w_winner;
  logic              w_found;
  logic              w_handshake;
  logic              w_load;

  // Channel index base+off, wrapped into 0..NUM_CH-1.
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
    logic [CH_W:0] sum;
    sum = {1'b0, base} + (CH_W+1)'(off);
    return (sum >= NUM_CH_L) ? CH_W'(sum - NUM_CH_L) : sum[CH_W-1:0];
  endfunction

  assign w_rise_det  = ~r_a_prev & a_i;
  assign w_fall_det  = r_a_prev & ~a_i;
  // A channel being reconfigured this cycle is not eligible for a grant.
  assign w_cand      = (r_rise_pend | r_fall_pend) & ~w_cfg_hit;
  assign w_found     = |w_cand;
  assign w_handshake = (r_state == ST_FULL) & evt_ready_i;
  assign w_load      = w_found & ((r_state == ST_EMPTY) | w_handshake);

  // Decode config hits and qualify detected edges by the channel's edge type.
  always_comb begin
    w_cfg_hit = '0;
    w_rise_en = '0;
    w_fall_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cfg_hit[i] = cfg_we_i & (cfg_ch_i == CH_W'(i));
      w_rise_en[i] = w_rise_det[i] & r_edge_type[i][0] & ~w_cfg_hit[i];
      w_fall_en[i] = w_fall_det[i] & r_edge_type[i][1] & ~w_cfg_hit[i];
    end
  end

  // Round-robin search; walking offsets downward lets the nearest candidate win.
  always_comb begin
    w_winner = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      w_winner = w_cand[rr_idx(r_rr_ptr, off)] ? rr_idx(r_rr_ptr, off) : w_winner;
    end
  end

  // Next pending/overflow state: a grant and a new edge in the same cycle re-arm cleanly.
  always_comb begin
    w_clr      = '0;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    w_ovf_nxt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_clr[i] = w_load & (w_winner == CH_W'(i));
      if (w_cfg_hit[i]) begin
        w_rise_nxt[i] = 1'b0;
        w_fall_nxt[i] = 1'b0;
        w_ovf_nxt[i]  = 1'b0;
      end else begin
        w_rise_nxt[i] = (r_rise_pend[i] & ~w_clr[i]) | w_rise_en[i];
        w_fall_nxt[i] = (r_fall_pend[i] & ~w_clr[i]) | w_fall_en[i];
        w_ovf_nxt[i]  = r_ovf[i]
                      | (w_rise_en[i] & r_rise_pend[i] & ~w_clr[i])
                      | (w_fall_en[i] & r_fall_pend[i] & ~w_clr[i]);
      end
    end
  end

  // Per-channel history, pending, overflow and edge-type registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_prev    <= '0;
      r_rise_pend <= '0;
      r_fall_pend <= '0;
      r_ovf       <= '0;
      r_pend      <= '0;
      r_edge_type <= '0;
    end else begin
      r_a_prev    <= a_i;
      r_rise_pend <= w_rise_nxt;
      r_fall_pend <= w_fall_nxt;
      r_ovf       <= w_ovf_nxt;
      r_pend      <= w_rise_nxt | w_fall_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfg_hit[i]) begin
          r_edge_type[i] <= cfg_edge_type_i;
        end
      end
    end
  end

  // One-entry event register: load on empty or on handshake, else hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_rr_ptr   <= '0;
      r_evt_ch   <= '0;
      r_evt_rise <= 1'b0;
      r_evt_fall <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY, ST_FULL: begin
          if (w_load) begin
            r_state    <= ST_FULL;
            r_evt_ch   <= w_winner;
            r_evt_rise <= r_rise_pend[w_winner];
            r_evt_fall <= r_fall_pend[w_winner];
            r_rr_ptr   <= (w_winner == LAST_CH) ? '0 : w_winner + 1'b1;
          end else if (w_handshake) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign evt_valid_o = (r_state == ST_FULL);
  assign evt_ch_o    = r_evt_ch;
  assign evt_rise_o  = r_evt_rise;
  assign evt_fall_o  = r_evt_fall;
  assign pend_o      = r_pend;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench: expected events are queued as edges are driven and
// compared by a monitor at each accepted handshake.
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            rise;
    logic            fall;
  } evt_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] a_i;
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [1:0]        cfg_edge_type_i;
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [CH_W-1:0]   evt_ch_o;
  logic              evt_rise_o;
  logic              evt_fall_o;
  logic [NUM_CH-1:0] pend_o;
  logic [NUM_CH-1:0] ovf_o;

  int   n_checks = 0;
  int   n_errors = 0;
  evt_t exp_q[$];

  edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .a_i             (a_i),
    .cfg_we_i        (cfg_we_i),
    .cfg_ch_i        (cfg_ch_i),
    .cfg_edge_type_i (cfg_edge_type_i),
    .evt_valid_o     (evt_valid_o),
    .evt_ready_i     (evt_ready_i),
    .evt_ch_o        (evt_ch_o),
    .evt_rise_o      (evt_rise_o),
    .evt_fall_o      (evt_fall_o),
    .pend_o          (pend_o),
    .ovf_o           (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input logic [1:0] t);
    @(negedge clk);
    cfg_we_i        = 1'b1;
    cfg_ch_i        = CH_W'(ch);
    cfg_edge_type_i = t;
    @(negedge clk);
    cfg_we_i        = 1'b0;
  endtask

  task automatic push(input int ch, input logic r, input logic f);
    evt_t e;
    e.ch   = CH_W'(ch);
    e.rise = r;
    e.fall = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexp_evt", {29'd0, evt_ch_o, evt_rise_o}, 32'hFFFF_FFFF);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("evt_ch",   32'(evt_ch_o),   32'(e.ch));
        chk("evt_rise", 32'(evt_rise_o), 32'(e.rise));
        chk("evt_fall", 32'(evt_fall_o), 32'(e.fall));
      end
    end
  end

  initial begin
    reset           = 1'b0;
    a_i             = 4'b0000;
    cfg_we_i        = 1'b0;
    cfg_ch_i        = 2'd0;
    cfg_edge_type_i = 2'b00;
    evt_ready_i     = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(evt_valid_o), 32'd0);
    chk("rst_ch",    32'(evt_ch_o),    32'd0);
    chk("rst_rise",  32'(evt_rise_o),  32'd0);
    chk("rst_fall",  32'(evt_fall_o),  32'd0);
    chk("rst_pend",  32'(pend_o),      32'd0);
    chk("rst_ovf",   32'(ovf_o),       32'd0);
    reset = 1'b1;
    cyc(2);

    // Single rising event on ch1 with two-clock latency.
    cfg(1, 2'b01);
    a_i[1] = 1'b1;
    push(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_pend1",  32'(pend_o[1]),  32'd1);
    chk("t1_nolat",  32'(evt_valid_o), 32'd0);
    @(negedge clk);
    chk("t1_valid",  32'(evt_valid_o), 32'd1);
    chk("t1_pclr",   32'(pend_o),      32'd0);
    @(negedge clk);
    chk("t1_oneclk", 32'(evt_valid_o), 32'd0);

    // Falling-only channel ignores the rising edge.
    a_i[0] = 1'b1;
    cyc(2);
    cfg(0, 2'b10);
    a_i[0] = 1'b0;
    push(0, 1'b0, 1'b1);
    cyc(4);
    a_i[0] = 1'b1;
    cyc(4);
    chk("t2_pend", 32'(pend_o), 32'd0);

    // Fresh reset, all channels both-edge, toggle together: 0,1,2,3 back-to-back.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) cfg(c, 2'b11);
    cyc(1);
    a_i = 4'b1100;
    push(0, 1'b0, 1'b1);
    push(1, 1'b0, 1'b1);
    push(2, 1'b1, 1'b0);
    push(3, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      @(negedge clk);
      chk("t3_nobubble", 32'(evt_valid_o), 32'd1);
    end
    @(negedge clk);
    chk("t3_drained", 32'(evt_valid_o), 32'd0);
    // Pointer back at 0: ch1 must beat ch3.
    a_i = 4'b0110;
    push(1, 1'b1, 1'b0);
    push(3, 1'b0, 1'b1);
    cyc(5);

    // Held event with merged edges and overflow on ch2, cleared by config.
    cfg(2, 2'b00);
    a_i[2] = 1'b0;
    cyc(2);
    cfg(2, 2'b11);
    evt_ready_i = 1'b0;
    a_i[2] = 1'b1;
    push(2, 1'b1, 1'b0);
    cyc(2);
    a_i[2] = 1'b0;
    cyc(2);
    a_i[2] = 1'b1;
    cyc(2);
    a_i[2] = 1'b0;
    cyc(2);
    chk("t4_valid", 32'(evt_valid_o), 32'd1);
    chk("t4_ch",    32'(evt_ch_o),    32'd2);
    chk("t4_rise",  32'(evt_rise_o),  32'd1);
    chk("t4_fall",  32'(evt_fall_o),  32'd0);
    chk("t4_pend2", 32'(pend_o[2]),   32'd1);
    chk("t4_ovf2",  32'(ovf_o[2]),    32'd1);
    cfg(2, 2'b11);
    chk("t4_pclr",  32'(pend_o[2]),   32'd0);
    chk("t4_oclr",  32'(ovf_o[2]),    32'd0);
    chk("t4_held",  32'(evt_valid_o), 32'd1);
    chk("t4_hch",   32'(evt_ch_o),    32'd2);
    evt_ready_i = 1'b1;
    cyc(3);
    chk("t4_empty", 32'(evt_valid_o), 32'd0);

    // Config write coinciding with an edge discards it; new type applies after.
    @(negedge clk);
    cfg_we_i        = 1'b1;
    cfg_ch_i        = 2'd1;
    cfg_edge_type_i = 2'b10;
    a_i[1]          = 1'b0;
    @(negedge clk);
    cfg_we_i = 1'b0;
    cyc(3);
    chk("t5_nopend", 32'(pend_o[1]), 32'd0);
    a_i[1] = 1'b1;
    cyc(3);
    a_i[1] = 1'b0;
    push(1, 1'b0, 1'b1);
    cyc(4);

    // Reset while ch3 event is held discards everything.
    a_i[3] = 1'b0;
    cfg(3, 2'b01);
    evt_ready_i = 1'b0;
    a_i[3] = 1'b1;
    push(3, 1'b1, 1'b0);
    cyc(3);
    chk("t6_valid", 32'(evt_valid_o), 32'd1);
    chk("t6_ch",    32'(evt_ch_o),    32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rvalid", 32'(evt_valid_o), 32'd0);
    chk("t6_rch",    32'(evt_ch_o),    32'd0);
    chk("t6_rrise",  32'(evt_rise_o),  32'd0);
    chk("t6_rpend",  32'(pend_o),      32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    evt_ready_i = 1'b1;
    cyc(2);
    a_i[3] = 1'b0;
    cyc(2);
    a_i[3] = 1'b1;
    cyc(4);
    chk("t6_noevt",  32'(evt_valid_o), 32'd0);
    chk("t6_nopend", 32'(pend_o),      32'd0);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
